// File: rtl/surf_sync_pkg.sv
// rtl/surf_sync_pkg.sv - shared state type and default sizing for the sync scheduler
package surf_sync_pkg;

  localparam int DEF_NCHAN       = 4;
  localparam int DEF_OFFSET_BITS = 5;
  localparam int DEF_CNT_BITS    = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_COUNT,
    ST_MEASURE
  } sync_state_t;

endpackage

// File: rtl/surf_sync_sysref_meas.sv
// rtl/surf_sync_sysref_meas.sv - sync-to-SYSREF cycle counter, edge detector and result latch
module surf_sync_sysref_meas
  import surf_sync_pkg::*;
#(
  parameter int CNT_BITS = DEF_CNT_BITS
) (
  input  logic                aclk_i,
  input  logic                aclk_rstn_i,
  input  logic                i_clear,
  input  logic                i_active,
  input  logic                i_meas_en,
  input  logic                i_accept,
  input  logic                i_measure,
  input  logic                i_sysref,
  output logic [CNT_BITS-1:0] o_count,
  output logic                o_valid,
  output logic                o_timeout,
  output logic                o_edge_hit,
  output logic                o_saturated
);

  logic                r_sysref_d;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] r_latch;
  logic                r_valid;
  logic                r_timeout;
  logic                w_saturated;
  logic                w_edge_hit;

  assign w_saturated = (r_cnt == '1);
  // Only the first rising edge of a request is taken; r_valid blocks the rest.
  assign w_edge_hit  = i_active && i_meas_en && !r_valid && i_sysref && !r_sysref_d;

  // Counter runs while scheduling/measuring, latch captures it on the first edge.
  always_ff @(posedge aclk_i or negedge aclk_rstn_i) begin
    if (!aclk_rstn_i) begin
      r_sysref_d <= 1'b0;
      r_cnt      <= '0;
      r_latch    <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_sysref_d <= i_sysref;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_active && !w_saturated) begin
        r_cnt <= r_cnt + CNT_BITS'(1);
      end
      if (i_accept) begin
        r_valid   <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        if (w_edge_hit) begin
          r_latch <= r_cnt;
          r_valid <= 1'b1;
        end
        if (i_measure && w_saturated && !w_edge_hit) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign o_count     = r_latch;
  assign o_valid     = r_valid;
  assign o_timeout   = r_timeout;
  assign o_edge_hit  = w_edge_hit;
  assign o_saturated = w_saturated;

endmodule

// File: rtl/surf_sync_scheduler.sv
// rtl/surf_sync_scheduler.sv - phase-aligned multi-channel sync pulse scheduler
module surf_sync_scheduler
  import surf_sync_pkg::*;
#(
  parameter int NCHAN       = DEF_NCHAN,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS,
  parameter int CNT_BITS    = DEF_CNT_BITS
) (
  input  logic                         aclk_i,
  input  logic                         aclk_rstn_i,
  input  logic                         aclk_phase_i,
  input  logic                         sync_req_i,
  input  logic [NCHAN-1:0]             chan_en_i,
  input  logic [NCHAN*OFFSET_BITS-1:0] sync_offset_i,
  input  logic                         sysref_meas_en_i,
  input  logic                         sysref_i,
  output logic [NCHAN-1:0]             sync_o,
  output logic                         busy_o,
  output logic                         req_dropped_o,
  output logic [CNT_BITS-1:0]          sysref_count_o,
  output logic                         sysref_valid_o,
  output logic                         sysref_timeout_o
);

  sync_state_t                  r_state;
  logic [OFFSET_BITS-1:0]       r_period;
  logic [NCHAN-1:0]             r_chan_en;
  logic [NCHAN*OFFSET_BITS-1:0] r_offset;
  logic                         r_meas_en;
  logic [NCHAN-1:0]             r_sync;
  logic                         r_req_dropped;

  logic [OFFSET_BITS-1:0]       w_terminal;
  logic [OFFSET_BITS-1:0]       w_period_inc;
  logic [NCHAN-1:0]             w_hit_zero;
  logic [NCHAN-1:0]             w_hit_next;
  logic                         w_accept;
  logic                         w_clear;
  logic                         w_active;
  logic                         w_measure;
  logic                         w_valid;
  logic                         w_edge_hit;
  logic                         w_saturated;
  logic                         w_meas_latched;

  assign w_accept     = (r_state == ST_IDLE) && sync_req_i;
  assign w_clear      = (r_state == ST_ARMED) && aclk_phase_i;
  assign w_active     = (r_state == ST_COUNT) || (r_state == ST_MEASURE);
  assign w_measure    = (r_state == ST_MEASURE);
  assign w_period_inc = (r_period == '1) ? r_period : r_period + OFFSET_BITS'(1);
  assign w_meas_latched = w_valid || w_edge_hit;

  // Terminal period is the largest offset among enabled channels.
  always_comb begin
    w_terminal = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (r_chan_en[c] && (r_offset[c*OFFSET_BITS +: OFFSET_BITS] > w_terminal)) begin
        w_terminal = r_offset[c*OFFSET_BITS +: OFFSET_BITS];
      end
    end
  end

  // Channels due at period 0 and at the period about to begin.
  always_comb begin
    w_hit_zero = '0;
    w_hit_next = '0;
    for (int c = 0; c < NCHAN; c++) begin
      w_hit_zero[c] = r_chan_en[c] && (r_offset[c*OFFSET_BITS +: OFFSET_BITS] == '0);
      w_hit_next[c] = r_chan_en[c] && (r_offset[c*OFFSET_BITS +: OFFSET_BITS] == w_period_inc);
    end
  end

  // Request acceptance, period stepping and registered pulse outputs.
  always_ff @(posedge aclk_i or negedge aclk_rstn_i) begin
    if (!aclk_rstn_i) begin
      r_state       <= ST_IDLE;
      r_period      <= '0;
      r_chan_en     <= '0;
      r_offset      <= '0;
      r_meas_en     <= 1'b0;
      r_sync        <= '0;
      r_req_dropped <= 1'b0;
    end else begin
      r_sync        <= '0;
      r_req_dropped <= sync_req_i && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (sync_req_i) begin
            r_chan_en <= chan_en_i;
            r_offset  <= sync_offset_i;
            r_meas_en <= sysref_meas_en_i;
            r_state   <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (aclk_phase_i) begin
            r_period <= '0;
            r_sync   <= w_hit_zero;
            r_state  <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (r_period == w_terminal) begin
            r_state <= (r_meas_en && !w_meas_latched) ? ST_MEASURE : ST_IDLE;
          end else if (aclk_phase_i) begin
            r_period <= w_period_inc;
            r_sync   <= w_hit_next;
          end
        end
        ST_MEASURE: begin
          if (w_meas_latched || w_saturated) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  surf_sync_sysref_meas #(
    .CNT_BITS (CNT_BITS)
  ) u_meas (
    .aclk_i      (aclk_i),
    .aclk_rstn_i (aclk_rstn_i),
    .i_clear     (w_clear),
    .i_active    (w_active),
    .i_meas_en   (r_meas_en),
    .i_accept    (w_accept),
    .i_measure   (w_measure),
    .i_sysref    (sysref_i),
    .o_count     (sysref_count_o),
    .o_valid     (w_valid),
    .o_timeout   (sysref_timeout_o),
    .o_edge_hit  (w_edge_hit),
    .o_saturated (w_saturated)
  );

  assign sync_o         = r_sync;
  assign busy_o         = (r_state != ST_IDLE);
  assign req_dropped_o  = r_req_dropped;
  assign sysref_valid_o = w_valid;

endmodule

// File: doc/surf_sync_scheduler.md
SURF_SYNC_SCHEDULER -- requirements
Module: surf_sync_scheduler

Interface
REQ-001 NCHAN, 4, number of independent sync output channels (1..16).
REQ-002 OFFSET_BITS, 5, width of per-channel offset in aclk phase periods.
REQ-003 CNT_BITS, 12, width of the sync-to-SYSREF aclk cycle counter.
REQ-004 aclk_i  in  1  sole clock; all ports synchronous to it.
REQ-005 aclk_rstn_i  in  1  reset, asynchronous, active-low.
REQ-006 aclk_phase_i  in  1  one-cycle strobe marking each aclk phase-period boundary.
REQ-007 sync_req_i  in  1  sync request, sampled every cycle.
REQ-008 chan_en_i  in  NCHAN  per-channel enable, snapshotted at request acceptance.
REQ-009 sync_offset_i  in  NCHAN*OFFSET_BITS  per-channel offset in phase periods, channel c at [c*OFFSET_BITS +: OFFSET_BITS], snapshotted at acceptance.
REQ-010 sysref_meas_en_i  in  1  enables SYSREF measurement, snapshotted at acceptance.
REQ-011 sysref_i  in  1  SYSREF level, already synchronous to aclk_i.
REQ-012 sync_o  out  NCHAN  per-channel one-cycle sync pulses.
REQ-013 busy_o  out  1  high whenever the FSM is not IDLE.
REQ-014 req_dropped_o  out  1  one-cycle pulse when a request is ignored.
REQ-015 sysref_count_o  out  CNT_BITS  latched sync-to-SYSREF cycle count.
REQ-016 sysref_valid_o  out  1  sysref_count_o valid; sticky until the next accepted request.
REQ-017 sysref_timeout_o  out  1  measurement saturated without a SYSREF edge; sticky until the next accepted request.

Function
REQ-018 FSM states IDLE, ARMED, COUNT, MEASURE; busy_o = (state != IDLE).
REQ-019 IDLE and sync_req_i high -> accept: snapshot enables, offsets and meas-enable; clear sysref_valid_o and sysref_timeout_o; go ARMED.
REQ-020 sync_req_i high in any state other than IDLE -> request ignored, req_dropped_o pulses the next cycle, no state change.
REQ-021 An aclk_phase_i in the acceptance cycle is not counted; period 0 begins at the first aclk_phase_i strictly after acceptance.
REQ-022 ARMED and aclk_phase_i high -> period counter = 0, sysref counter = 0, go COUNT.
REQ-023 COUNT: each aclk_phase_i increments the period counter by 1; the counter is OFFSET_BITS wide and never wraps.
REQ-024 sync_o[c] is high for exactly one cycle: the cycle after the strobe that begins period offset[c], only if chan_en[c] is set; latency from that strobe is 1 cycle.
REQ-025 Channels with equal offsets pulse in the same cycle; each enabled channel pulses exactly once per accepted request.
REQ-026 Terminal period = max offset over enabled channels (0 if none enabled); after it begins, go MEASURE if meas-enable is set and no SYSREF edge has been latched yet, else go IDLE.
REQ-027 With no channels enabled, no sync_o pulse occurs; the FSM still passes through ARMED and COUNT.
REQ-028 The sysref counter increments every cycle in COUNT and MEASURE, saturating at 2^CNT_BITS-1.
REQ-029 SYSREF edge = sysref_i high while the registered previous sysref_i is low; edge detection is active in COUNT and MEASURE only.
REQ-030 The first edge after period 0 begins latches the counter value (value counted before the edge cycle) to sysref_count_o and sets sysref_valid_o; later edges in the same request are ignored.
REQ-031 MEASURE: on a latched edge go IDLE; if the counter saturates first, set sysref_timeout_o and go IDLE.
REQ-032 sync_offset_i and chan_en_i changes after acceptance have no effect until the next accepted request.

Reset
REQ-033 aclk_rstn_i low asynchronously forces state IDLE; clears sync_o, req_dropped_o, sysref_valid_o, sysref_timeout_o and all counters; sets sysref_count_o = 0.
REQ-034 Reset mid-operation aborts without emitting any further sync_o pulse; the first request after release behaves as from power-on.

Structure
REQ-035 Package surf_sync_pkg holds the FSM state enum typedef and the default values of NCHAN, OFFSET_BITS and CNT_BITS.
REQ-036 The sysref counter, edge detector and latch form sub-module surf_sync_sysref_meas; all other logic stays in the top module.

Verification
REQ-037 Strobe every 3 cycles; request with offsets {0,2,2,5}, all enabled -> sync_o[0] 1 cycle after the 1st strobe, sync_o[1] and sync_o[2] together after the 3rd strobe, sync_o[3] after the 6th; FSM then goes IDLE.
REQ-038 sync_req_i and aclk_phase_i in the same cycle -> the offset-0 channel fires after the next strobe, not the coincident one.
REQ-039 Second request while busy -> req_dropped_o pulses once, pulse timing unchanged; offsets changed mid-run -> no effect.
REQ-040 Meas enabled, SYSREF rising 40 cycles after period-0 start -> sysref_count_o = 40, sysref_valid_o = 1, then IDLE.
REQ-041 Meas enabled, no SYSREF, CNT_BITS = 6 -> sysref_timeout_o set at saturation (count 63), then IDLE.
REQ-042 Reset asserted between two channel pulses -> no further pulses, all outputs 0; a fresh request afterwards reproduces the REQ-037 timing.
